// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared widths and buffer geometry for the reorder buffer.
package rob_commit_pkg;
    localparam int TAG_BITS  = 4;
    localparam int DATA_BITS = 32;
    localparam int REG_BITS  = 5;
    localparam int ROB_SIZE  = 1 << TAG_BITS;
    localparam int ROB_LAST  = ROB_SIZE - 1;
endpackage

// File: rtl/rob_commit.sv
// rob_commit: in-order retirement buffer with CDB capture and operand query ports.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int TAG_W  = TAG_BITS,
    parameter int DATA_W = DATA_BITS,
    parameter int REG_W  = REG_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              rob_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data,
    output logic              commit_valid,
    output logic              commit_has_dest,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag
);
    localparam int N = 1 << TAG_W;
    localparam logic [TAG_W-1:0] LAST = TAG_W'(N - 1);
    localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);

    logic [N-1:0]      busy, ready, has_dest;
    logic [REG_W-1:0]  rd [N];
    logic [DATA_W-1:0] data [N];
    logic [TAG_W-1:0]  head, tail, count;
    logic              alloc_go, commit_go, wb_go;
    logic              q1_byp, q2_byp, q1_hit, q2_hit;

    // Tag 0 means "no producer", so the pointers wrap from LAST back to 1.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return t == LAST ? FIRST : t + FIRST;
    endfunction

    assign alloc_tag = tail;
    assign rob_full  = count == LAST;
    assign alloc_go  = rdy & alloc_valid & ~rob_full;
    assign commit_go = rdy & busy[head] & ready[head];
    assign wb_go     = rdy & cdb_valid & (cdb_tag != '0) & busy[cdb_tag];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head            <= FIRST;
            tail            <= FIRST;
            count           <= '0;
            busy            <= '0;
            ready           <= '0;
            commit_valid    <= 1'b0;
            commit_has_dest <= 1'b0;
            commit_rd       <= '0;
            commit_data     <= '0;
            commit_tag      <= '0;
        end else begin
            commit_valid    <= commit_go;
            commit_has_dest <= commit_go & has_dest[head];
            commit_rd       <= commit_go ? rd[head] : '0;
            commit_data     <= commit_go ? data[head] : '0;
            commit_tag      <= commit_go ? head : '0;
            if (wb_go) begin
                ready[cdb_tag] <= 1'b1;
                data[cdb_tag]  <= cdb_data;
            end
            if (alloc_go) begin
                busy[tail]     <= 1'b1;
                ready[tail]    <= 1'b0;
                has_dest[tail] <= alloc_has_dest;
                rd[tail]       <= alloc_rd;
                tail           <= next_tag(tail);
            end
            // Head retires after any same-cycle writeback, so its ready bit ends up clear.
            if (commit_go) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= next_tag(head);
            end
            count <= count + TAG_W'(alloc_go) - TAG_W'(commit_go);
        end
    end

    assign q1_byp   = cdb_valid && cdb_tag == q1_tag;
    assign q2_byp   = cdb_valid && cdb_tag == q2_tag;
    assign q1_hit   = busy[q1_tag] && ready[q1_tag];
    assign q2_hit   = busy[q2_tag] && ready[q2_tag];
    assign q1_ready = q1_tag == '0 || q1_byp || q1_hit;
    assign q2_ready = q2_tag == '0 || q2_byp || q2_hit;
    assign q1_data  = q1_tag == '0 ? '0 : q1_byp ? cdb_data : q1_hit ? data[q1_tag] : '0;
    assign q2_data  = q2_tag == '0 ? '0 : q2_byp ? cdb_data : q2_hit ? data[q2_tag] : '0;
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus random traffic against a program-order queue model.
module tb_rob_commit;
    logic        clk = 1'b0;
    logic        rst, rdy, flush, alloc_valid, alloc_has_dest, cdb_valid;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_tag, cdb_tag, q1_tag, q2_tag, commit_tag;
    logic        rob_full, q1_ready, q2_ready, commit_valid, commit_has_dest;
    logic [31:0] cdb_data, q1_data, q2_data, commit_data;
    logic [4:0]  commit_rd;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  tag;
        logic        hd;
        logic [4:0]  rd;
        logic        rdy;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_tail = 4'd1;
    logic        e_cv, e_hd;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [3:0]  e_tag;

    rob_commit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest), .alloc_rd(alloc_rd),
        .alloc_tag(alloc_tag), .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_data(q1_data), .q2_data(q2_data),
        .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
        .commit_rd(commit_rd), .commit_data(commit_data), .commit_tag(commit_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Reference: entries live in a program-order queue; the oldest retires once ready.
    task automatic model_step;
        e_cv = 0; e_hd = 0; e_rd = 0; e_data = 0; e_tag = 0;
        if (rst || flush) begin
            mq.delete();
            m_tail = 4'd1;
        end else if (rdy) begin
            bit c;
            c = mq.size() > 0 && mq[0].rdy;
            if (c) begin
                e_cv = 1; e_hd = mq[0].hd; e_rd = mq[0].rd; e_data = mq[0].data; e_tag = mq[0].tag;
            end
            if (cdb_valid && cdb_tag != 0)
                foreach (mq[i]) if (mq[i].tag == cdb_tag) begin mq[i].rdy = 1; mq[i].data = cdb_data; end
            if (alloc_valid && mq.size() < 15) begin
                mq.push_back('{tag: m_tail, hd: alloc_has_dest, rd: alloc_rd, rdy: 1'b0, data: 32'h0});
                m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
            end
            if (c) void'(mq.pop_front());
        end
    endtask

    function automatic logic [32:0] m_query(input logic [3:0] t);
        if (t == 0) return {1'b1, 32'h0};
        if (cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
        foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) return {1'b1, mq[i].data};
        return 33'h0;
    endfunction

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle;
        rdy = 1; flush = 0; alloc_valid = 0; alloc_has_dest = 0; alloc_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; q1_tag = 0; q2_tag = 0;
    endtask

    task automatic do_reset;
        set_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        set_idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_checks++; if (alloc_tag !== 4'd1) begin n_fail++; $display("FAIL reset_alloc_tag got %0d exp 1", alloc_tag); end
        n_checks++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", rob_full); end
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %b exp 0", commit_valid); end
        n_checks++; if ({commit_tag, commit_rd, commit_data, commit_has_dest} !== '0) begin n_fail++; $display("FAIL reset_commit_fields got %h/%h/%h exp 0", commit_tag, commit_rd, commit_data); end
    endtask

    task automatic test_in_order;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            alloc_valid = 1; alloc_has_dest = 1; alloc_rd = 5'(i);
            #1;
            n_checks++; if (alloc_tag !== 4'(i)) begin n_fail++; $display("FAIL inorder_alloc_tag got %0d exp %0d", alloc_tag, i); end
            tick();
        end
        alloc_valid = 0;
        tick();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_no_cdb_commit got %b exp 0", commit_valid); end
        cdb_valid = 1; cdb_tag = 2; cdb_data = 32'hAA;
        tick();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_tag2_early got %b exp 0", commit_valid); end
        cdb_tag = 1; cdb_data = 32'h55;
        tick();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_same_edge got %b exp 0", commit_valid); end
        cdb_valid = 0;
        tick();
        n_checks++; if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 4'd1, 5'd1, 32'h55}) begin n_fail++; $display("FAIL inorder_first got v%b t%0d rd%0d %h exp v1 t1 rd1 55", commit_valid, commit_tag, commit_rd, commit_data); end
        tick();
        n_checks++; if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 4'd2, 5'd2, 32'hAA}) begin n_fail++; $display("FAIL inorder_second got v%b t%0d rd%0d %h exp v1 t2 rd2 aa", commit_valid, commit_tag, commit_rd, commit_data); end
        tick();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_tag3_held got %b exp 0", commit_valid); end
        n_checks++; if (alloc_tag !== 4'd4) begin n_fail++; $display("FAIL inorder_tail got %0d exp 4", alloc_tag); end
    endtask

    task automatic test_full_wrap;
        int got;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1; alloc_has_dest = 1; alloc_rd = 5'(i + 1);
            #1;
            if (i == 14) begin n_checks++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", rob_full); end end
            if (i == 15) begin
                n_checks++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b exp 1", rob_full); end
                n_checks++; if (alloc_tag !== 4'd1) begin n_fail++; $display("FAIL full_tail got %0d exp 1", alloc_tag); end
            end
            tick();
        end
        alloc_valid = 0;
        n_checks++; if (rob_full !== 1'b1 || alloc_tag !== 4'd1) begin n_fail++; $display("FAIL full_ignored got full%b tag%0d exp full1 tag1", rob_full, alloc_tag); end
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 15; cyc++) begin
            cdb_valid = cyc < 15; cdb_tag = 4'(cyc + 1); cdb_data = 32'h100 + 32'(cyc);
            tick();
            if (commit_valid) begin
                n_checks++;
                if (commit_tag !== 4'(got + 1) || commit_data !== 32'h100 + 32'(got) || commit_rd !== 5'(got + 1)) begin
                    n_fail++; $display("FAIL drain_order got t%0d %h exp t%0d %h", commit_tag, commit_data, got + 1, 32'h100 + 32'(got));
                end
                got++;
            end
        end
        cdb_valid = 0;
        n_checks++; if (got !== 15) begin n_fail++; $display("FAIL drain_count got %0d exp 15", got); end
        n_checks++; if (alloc_tag !== 4'd1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL drain_wrap got tag%0d full%b exp tag1 full0", alloc_tag, rob_full); end
        alloc_valid = 1;
        tick();
        alloc_valid = 0;
        n_checks++; if (alloc_tag !== 4'd2) begin n_fail++; $display("FAIL wrap_next got %0d exp 2", alloc_tag); end
    endtask

    task automatic test_query;
        do_reset();
        alloc_valid = 1;
        repeat (5) tick();
        alloc_valid = 0;
        q1_tag = 5; q2_tag = 0; cdb_valid = 1; cdb_tag = 5; cdb_data = 32'h1234;
        #1;
        n_checks++; if ({q1_ready, q1_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL query_bypass got %b %h exp 1 1234", q1_ready, q1_data); end
        n_checks++; if ({q2_ready, q2_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL query_tag0 got %b %h exp 1 0", q2_ready, q2_data); end
        q2_tag = 3;
        #1;
        n_checks++; if ({q2_ready, q2_data} !== 33'h0) begin n_fail++; $display("FAIL query_pending got %b %h exp 0 0", q2_ready, q2_data); end
        tick();
        cdb_tag = 9; cdb_data = 32'hDEAD;
        tick();
        cdb_valid = 0; q2_tag = 9;
        #1;
        n_checks++; if ({q1_ready, q1_data} !== {1'b1, 32'h1234}) begin n_fail++; $display("FAIL query_stored got %b %h exp 1 1234", q1_ready, q1_data); end
        n_checks++; if ({q2_ready, q2_data} !== 33'h0) begin n_fail++; $display("FAIL query_idle_entry got %b %h exp 0 0", q2_ready, q2_data); end
    endtask

    task automatic test_flush;
        do_reset();
        alloc_valid = 1; alloc_has_dest = 1; alloc_rd = 4;
        tick();
        alloc_valid = 0; cdb_valid = 1; cdb_tag = 1; cdb_data = 32'h77;
        tick();
        cdb_valid = 0; flush = 1;
        tick();
        flush = 0; q1_tag = 1;
        #1;
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_commit got %b exp 0", commit_valid); end
        n_checks++; if (alloc_tag !== 4'd1 || rob_full !== 1'b0) begin n_fail++; $display("FAIL flush_ptrs got tag%0d full%b exp tag1 full0", alloc_tag, rob_full); end
        n_checks++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL flush_entry got %b exp 0", q1_ready); end
        tick();
        n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late_commit got %b exp 0", commit_valid); end
        alloc_valid = 1;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin n_checks++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL flush_count got full%b exp 0", rob_full); end end
            tick();
        end
        alloc_valid = 0;
        n_checks++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL flush_refill got %b exp 1", rob_full); end
    endtask

    task automatic test_rdy_low;
        do_reset();
        alloc_valid = 1; alloc_has_dest = 1; alloc_rd = 7;
        tick();
        alloc_rd = 8;
        tick();
        rdy = 0; alloc_rd = 9; cdb_valid = 1; cdb_tag = 1; cdb_data = 32'hBEEF; q2_tag = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (alloc_tag !== 4'd3 || q2_ready !== 1'b0) begin n_fail++; $display("FAIL stall_state got tag%0d q2r%b exp tag3 q2r0", alloc_tag, q2_ready); end
            tick();
            n_checks++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL stall_commit got %b exp 0", commit_valid); end
        end
        rdy = 1; alloc_valid = 0; cdb_valid = 0;
        tick();
        n_checks++; if (commit_valid !== 1'b0 || alloc_tag !== 4'd3) begin n_fail++; $display("FAIL resume_state got v%b tag%0d exp v0 tag3", commit_valid, alloc_tag); end
        cdb_valid = 1;
        tick();
        cdb_valid = 0;
        tick();
        n_checks++; if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 4'd1, 5'd7, 32'hBEEF}) begin n_fail++; $display("FAIL resume_commit got v%b t%0d rd%0d %h exp v1 t1 rd7 beef", commit_valid, commit_tag, commit_rd, commit_data); end
    endtask

    task automatic test_random;
        logic [32:0] e1, e2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 59) == 0;
            alloc_valid = $urandom_range(0, 2) != 0;
            alloc_has_dest = 1'($urandom);
            alloc_rd = 5'($urandom);
            cdb_valid = $urandom_range(0, 2) != 0;
            cdb_tag = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom_range(0, 15));
            cdb_data = $urandom;
            q1_tag = (mq.size() > 0 && $urandom_range(0, 1) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : 4'($urandom_range(0, 15));
            q2_tag = 4'($urandom_range(0, 15));
            #1;
            e1 = m_query(q1_tag);
            e2 = m_query(q2_tag);
            n_checks++; if (alloc_tag !== m_tail || rob_full !== (mq.size() == 15)) begin n_fail++; $display("FAIL rand_tail c%0d got tag%0d full%b exp tag%0d full%b", cyc, alloc_tag, rob_full, m_tail, mq.size() == 15); end
            n_checks++; if ({q1_ready, q1_data} !== e1) begin n_fail++; $display("FAIL rand_q1 c%0d got %b %h exp %h", cyc, q1_ready, q1_data, e1); end
            n_checks++; if ({q2_ready, q2_data} !== e2) begin n_fail++; $display("FAIL rand_q2 c%0d got %b %h exp %h", cyc, q2_ready, q2_data, e2); end
            tick();
            n_checks++; if (commit_valid !== e_cv) begin n_fail++; $display("FAIL rand_commit_valid c%0d got %b exp %b", cyc, commit_valid, e_cv); end
            if (e_cv) begin
                n_checks++;
                if ({commit_tag, commit_rd, commit_data, commit_has_dest} !== {e_tag, e_rd, e_data, e_hd}) begin
                    n_fail++; $display("FAIL rand_commit c%0d got t%0d rd%0d %h hd%b exp t%0d rd%0d %h hd%b", cyc, commit_tag, commit_rd, commit_data, commit_has_dest, e_tag, e_rd, e_data, e_hd);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_query();
        test_flush();
        test_rdy_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer for the out-of-order core.
- Allocates a rename tag per decoded instruction and captures results broadcast on the CDB.
- Retires entries in program order, one per cycle.
- The commit port writes the architectural register file and clears its busy/tag state. The query ports give dispatch the values of in-flight producers.
- Sits between ID/dispatch (allocation, query), execution units (CDB) and the register file (commit).

Parameters:
- TAG_W, 4, tag width; entries are tags 1..2^TAG_W-1 (15). Tag 0 means "no producer".
- DATA_W, 32, data width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  mispredict flush; empties the buffer
- alloc_valid  in  1  ID requests one entry this cycle
- alloc_has_dest  in  1  instruction writes a register
- alloc_rd  in  REG_W  destination register
- alloc_tag  out  TAG_W  tag that is granted if alloc_valid (current tail)
- rob_full  out  1  no free entry; ID must stall
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producer tag
- cdb_data  in  DATA_W  result
- q1_tag, q2_tag  in  TAG_W  operand producer tags from the regfile
- q1_ready, q2_ready  out  1  producer result available
- q1_data, q2_data  out  DATA_W  producer result
- commit_valid  out  1  one-cycle retire pulse
- commit_has_dest  out  1  retiring entry writes a register
- commit_rd  out  REG_W  destination register
- commit_data  out  DATA_W  value written
- commit_tag  out  TAG_W  tag retired; the regfile clears busy only if its stored tag equals this

Behaviour:
- Storage: per entry busy, ready, has_dest, rd, data. Registers head, tail and count.
- Reset (and flush): head=tail=1, count=0, all busy/ready cleared, commit_valid=0, other commit outputs 0. rst has priority over flush, and flush has priority over all other events.
- Index wrap: tags advance 1..15 then back to 1. Tag 0 is never issued.
- rob_full = (count==15), combinational from registered count. There is no same-cycle bypass through a commit; alloc while full is ignored.
- Allocation (rdy & alloc_valid & !rob_full):
  - entry[tail] gets busy=1, ready=0, has_dest and rd.
  - tail advances.
  - alloc_tag always shows the current tail.
- Writeback (rdy & cdb_valid, cdb_tag!=0, entry busy): ready=1, data=cdb_data. A CDB hit on a non-busy entry or on tag 0 is ignored.
- Commit: if rdy & entry[head].busy & entry[head].ready, then the next edge:
  - sets commit_valid=1 and drives commit_* from the head entry;
  - clears busy/ready at head;
  - advances head.
  - Otherwise commit_valid=0 at that edge.
- Commit latency: CDB write at edge N makes the entry ready at edge N; commit is registered at edge N+1 at the earliest. Commit rate is at most one per cycle.
- count: +1 on alloc, −1 on commit, unchanged when both or neither occur.
- Simultaneous events:
  - Alloc into a slot freed by the same-cycle commit is not possible (full is checked first).
  - CDB write to head in the same cycle does not commit that cycle.
- Query (combinational), with priority:
  - tag 0: ready=1, data=0.
  - cdb_valid & cdb_tag==q_tag: ready=1, data=cdb_data (bypass).
  - entry busy & ready: ready=1, data=entry data.
  - otherwise ready=0, data=0.
- rdy low: no alloc, writeback or commit; commit_valid driven 0; queries still answer.
- Flush mid-operation: all entries discarded. A commit_valid registered on the flush edge is not produced.

Decomposition:
- TagBus, DataBus, RegBus, Valid/Invalid and Null go in the shared cpu_define.v header. Add ROB_SIZE (16) and ROB_LAST (15).
- No sub-module: the entry array and pointer logic stay in one module, about 200 lines.

Test Plan:
- Reset then alloc 3 instructions (rd=1,2,3) → alloc_tag 1,2,3, count=3; no commit_valid without CDB.
- CDB tag2=0xAA, then tag1=0x55 → commits in order: tag1 rd1 0x55, then tag2 rd2 0xAA on consecutive cycles; tag3 held.
- Alloc 15 with none retiring → rob_full=1 and 16th alloc ignored. Then ready all and drain: tags commit 1..15. Next alloc_tag=1 (wrap skips 0).
- Query q1_tag=5 while cdb_valid tag5=0x1234 → q1_ready=1, q1_data=0x1234 same cycle. q2_tag=0 → ready=1, data=0.
- Commit pending at head with flush asserted → no commit_valid; head=tail=1, count=0, rob_full=0.
- rdy low for 3 cycles with alloc and CDB driven → no state change, commit_valid=0; resumes unchanged when rdy returns high.
